// File: rtl/instr_dcd_burst.sv
// instr_dcd_burst
//   Decodes an SPI-style register access protocol. The first byte of each
//   frame is an instruction (bit7 write/read, bit6 burst/single, low ADDR_W
//   bits start address). The bytes that follow are data bytes. Each data
//   byte becomes a one-cycle register write strobe (write mode) or triggers
//   the read prefetch for the next byte to be shifted out (read mode).
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   cs_n            : frame select (high = idle), synchronous to clk
//   byte_sync       : one-cycle pulse, data_in holds a complete byte
//   data_in         : received byte
//   data_out        : last value read from the register file
//   read / write    : one-cycle register strobes, never high together
//   addr            : register address, valid with read/write
//   data_read       : register read data, combinational from addr
//   data_write      : register write data, valid with write
//   err             : sticky frame error (address out of range)
//   busy            : high while the frame is past its instruction byte
module instr_dcd_burst #(
  parameter int ADDR_W    = 6,
  parameter int REG_COUNT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_read,
  output logic [7:0]        data_write,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_INSTR = 2'd0,
    S_DATA  = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Highest implemented address, one bit wider than the address so that
  // REG_COUNT == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(REG_COUNT - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} <= LAST);
  endfunction

  // Auto-increment with wrap at the last implemented register.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if ({1'b0, a} == LAST) return '0;
    else                   return a + ADDR_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic              wr_mode_q, wr_mode_d;
  logic              burst_q, burst_d;
  // In write mode ptr points at the next register to write; in read mode it
  // points at the register most recently read.
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [7:0]        dwr_q, dwr_d;
  logic [7:0]        dout_q, dout_d;
  logic              err_q, err_d;
  logic              cs_n_q;
  logic [ADDR_W-1:0] instr_addr;

  assign instr_addr = data_in[ADDR_W-1:0];

  always_comb begin
    state_d   = state_q;
    wr_mode_d = wr_mode_q;
    burst_d   = burst_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    read_d    = 1'b0;
    write_d   = 1'b0;
    dwr_d     = dwr_q;
    err_d     = err_q;
    // Read data is captured the cycle after the strobe, whatever happens to
    // the frame in the meantime.
    dout_d    = read_q ? data_read : dout_q;

    // First cycle of a new frame clears the sticky error.
    if (cs_n_q && !cs_n) err_d = 1'b0;

    if (cs_n) begin
      state_d = S_INSTR;
    end else if (byte_sync) begin
      unique case (state_q)
        S_INSTR: begin
          wr_mode_d = data_in[7];
          burst_d   = data_in[6];
          ptr_d     = instr_addr;
          if (!in_range(instr_addr)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
            // Read mode prefetches the first register immediately so the
            // byte is ready before the first data byte is shifted out.
            if (!data_in[7]) begin
              read_d = 1'b1;
              addr_d = instr_addr;
            end
          end
        end
        S_DATA: begin
          if (wr_mode_q) begin
            write_d = 1'b1;
            addr_d  = ptr_q;
            dwr_d   = data_in;
            if (burst_q) ptr_d = next_addr(ptr_q);
          end else if (burst_q) begin
            read_d = 1'b1;
            addr_d = next_addr(ptr_q);
            ptr_d  = next_addr(ptr_q);
          end
          state_d = burst_q ? S_DATA : S_DONE;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_INSTR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INSTR;
      wr_mode_q <= 1'b0;
      burst_q   <= 1'b0;
      ptr_q     <= '0;
      addr_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      dwr_q     <= 8'h00;
      dout_q    <= 8'h00;
      err_q     <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_mode_q <= wr_mode_d;
      burst_q   <= burst_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      write_q   <= write_d;
      dwr_q     <= dwr_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
      cs_n_q    <= cs_n;
    end
  end

  assign data_out   = dout_q;
  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign data_write = dwr_q;
  assign err        = err_q;
  assign busy       = (state_q != S_INSTR);

endmodule

// File: tb/tb_instr_dcd_burst.sv
module tb_instr_dcd_burst;

  logic       clk = 1'b0;
  logic       rst, cs_n, byte_sync;
  logic [7:0] data_in;

  logic [7:0] data_out, data_read, data_write;
  logic       read, write, err, busy;
  logic [5:0] addr;

  logic [7:0] b_data_out, b_data_read, b_data_write;
  logic       b_read, b_write, b_err, b_busy;
  logic [5:0] b_addr;

  logic [7:0] regs [64];

  always #5 clk = ~clk;

  instr_dcd_burst #(.ADDR_W(6), .REG_COUNT(64)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .byte_sync(byte_sync), .data_in(data_in),
    .data_out(data_out), .read(read), .write(write), .addr(addr),
    .data_read(data_read), .data_write(data_write), .err(err), .busy(busy)
  );

  instr_dcd_burst #(.ADDR_W(6), .REG_COUNT(16)) dut16 (
    .clk(clk), .rst(rst), .cs_n(cs_n), .byte_sync(byte_sync), .data_in(data_in),
    .data_out(b_data_out), .read(b_read), .write(b_write), .addr(b_addr),
    .data_read(b_data_read), .data_write(b_data_write), .err(b_err), .busy(b_busy)
  );

  assign data_read   = regs[addr];
  assign b_data_read = regs[b_addr];

  typedef struct {
    bit         is_wr;
    logic [5:0] a;
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   b_strobes = 0;
  bit   started  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data_in   = b;
    byte_sync = 1'b1;
    @(posedge clk);
    #1;
    byte_sync = 1'b0;
    idle(3);
  endtask

  task automatic exp_rd(input int a);
    exp_t e;
    e.is_wr = 1'b0; e.a = 6'(a); e.d = 8'h00; e.c = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic exp_wr(input int a, input logic [7:0] d);
    exp_t e;
    e.is_wr = 1'b1; e.a = 6'(a); e.d = d; e.c = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic monitor();
    logic [7:0] exp_dout = 8'h00;
    logic       rst_s = 1'b1, rd_s = 1'b0;
    logic [5:0] ad_s = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst_s) exp_dout = 8'h00;
      else if (rd_s === 1'b1) exp_dout = regs[ad_s];
      if (started) begin
        checks++;
        if (data_out !== exp_dout) begin
          failures++;
          $display("FAIL data_out cyc=%0d: got %h expected %h", cyc, data_out, exp_dout);
        end
        if (read === 1'b1 && write === 1'b1) begin
          checks++; failures++;
          $display("FAIL strobe_excl cyc=%0d: read=1 write=1 expected not both", cyc);
        end
        if (read === 1'b1 || write === 1'b1) begin
          checks++;
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe cyc=%0d: read=%b write=%b addr=%0d expected none", cyc, read, write, addr);
          end else begin
            e = sbq.pop_front();
            if (write !== e.is_wr || addr !== e.a || cyc != e.c ||
                (e.is_wr && data_write !== e.d)) begin
              failures++;
              $display("FAIL sb_strobe: got wr=%b addr=%0d data=%h cyc=%0d expected wr=%b addr=%0d data=%h cyc=%0d",
                       write, addr, data_write, cyc, e.is_wr, e.a, e.d, e.c);
            end
          end
        end
        if (b_read === 1'b1 || b_write === 1'b1) b_strobes++;
      end
      rst_s = rst;
      rd_s  = read;
      ad_s  = addr;
    end
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_missing: got %0d pending strobes expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; byte_sync = 1'b0; data_in = 8'h00;
    idle(2);
    // byte while in reset must be ignored
    cs_n = 1'b0; byte_sync = 1'b1; data_in = 8'h03;
    idle(1);
    byte_sync = 1'b0;
    idle(1);
    checks += 7;
    if (read !== 1'b0)        begin failures++; $display("FAIL rst_read: got %b expected 0", read); end
    if (write !== 1'b0)       begin failures++; $display("FAIL rst_write: got %b expected 0", write); end
    if (addr !== 6'd0)        begin failures++; $display("FAIL rst_addr: got %0d expected 0", addr); end
    if (data_write !== 8'h00) begin failures++; $display("FAIL rst_dwr: got %h expected 00", data_write); end
    if (data_out !== 8'h00)   begin failures++; $display("FAIL rst_dout: got %h expected 00", data_out); end
    if (err !== 1'b0)         begin failures++; $display("FAIL rst_err: got %b expected 0", err); end
    if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
    started = 1'b1;
    cs_n = 1'b1;
    rst  = 1'b0;
    idle(2);
  endtask

  task automatic test_single_write();
    cs_n = 1'b0; idle(1);
    send(8'h85);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL sw_busy: got %b expected 1", busy); end
    exp_wr(5, 8'h5A); send(8'h5A);
    send(8'h11);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL sw_busy_done: got %b expected 1", busy); end
    cs_n = 1'b1; idle(2);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL sw_busy_idle: got %b expected 0", busy); end
    check_empty("single_write");
  endtask

  task automatic test_burst_read();
    cs_n = 1'b0; idle(1);
    exp_rd(3); send(8'h43);
    checks++;
    if (data_out !== 8'hA3) begin failures++; $display("FAIL br_d0: got %h expected a3", data_out); end
    exp_rd(4); send(8'h00);
    checks++;
    if (data_out !== 8'hB4) begin failures++; $display("FAIL br_d1: got %h expected b4", data_out); end
    exp_rd(5); send(8'h00);
    checks++;
    if (data_out !== regs[5]) begin failures++; $display("FAIL br_d2: got %h expected %h", data_out, regs[5]); end
    cs_n = 1'b1; idle(2);
    check_empty("burst_read");
  endtask

  task automatic test_burst_wrap();
    cs_n = 1'b0; idle(1);
    send(8'hFE);
    exp_wr(62, 8'h01); send(8'h01);
    exp_wr(63, 8'h02); send(8'h02);
    exp_wr(0,  8'h03); send(8'h03);
    cs_n = 1'b1; idle(2);
    check_empty("burst_wrap");
  endtask

  task automatic test_out_of_range();
    int b0;
    b0 = b_strobes;
    cs_n = 1'b0; idle(2);
    checks++;
    if (b_err !== 1'b0) begin failures++; $display("FAIL oor_err_newframe: got %b expected 0", b_err); end
    send(8'h94);
    checks += 2;
    if (b_err !== 1'b1)  begin failures++; $display("FAIL oor_err: got %b expected 1", b_err); end
    if (b_busy !== 1'b1) begin failures++; $display("FAIL oor_busy: got %b expected 1", b_busy); end
    exp_wr(20, 8'h77); send(8'h77);
    checks += 2;
    if (b_err !== 1'b1)    begin failures++; $display("FAIL oor_err_hold: got %b expected 1", b_err); end
    if (b_strobes != b0)   begin failures++; $display("FAIL oor_strobes: got %0d expected 0", b_strobes - b0); end
    cs_n = 1'b1; idle(1);
    checks++;
    if (b_err !== 1'b1) begin failures++; $display("FAIL oor_err_csn: got %b expected 1", b_err); end
    cs_n = 1'b0; idle(2);
    checks += 2;
    if (b_err !== 1'b0)  begin failures++; $display("FAIL oor_err_clr: got %b expected 0", b_err); end
    if (b_busy !== 1'b0) begin failures++; $display("FAIL oor_state: got busy=%b expected 0", b_busy); end
    cs_n = 1'b1; idle(2);
    check_empty("out_of_range");
  endtask

  task automatic test_abort();
    cs_n = 1'b0; idle(1);
    send(8'hC0);
    exp_wr(0, 8'h10); send(8'h10);
    cs_n = 1'b1;
    send(8'h43);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ab_busy: got %b expected 0", busy); end
    cs_n = 1'b0; idle(1);
    exp_rd(2); send(8'h02);
    checks++;
    if (data_out !== regs[2]) begin failures++; $display("FAIL ab_dout: got %h expected %h", data_out, regs[2]); end
    send(8'h00);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL ab_busy_done: got %b expected 1", busy); end
    cs_n = 1'b1; idle(2);
    check_empty("abort");
  endtask

  task automatic test_reset_mid();
    cs_n = 1'b0; idle(1);
    exp_rd(3); send(8'h43);
    exp_rd(4); send(8'h00);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rm_busy: got %b expected 1", busy); end
    rst = 1'b1; idle(1);
    rst = 1'b0;
    checks += 6;
    if (read !== 1'b0 || write !== 1'b0) begin failures++; $display("FAIL rm_strobe: got r=%b w=%b expected 0 0", read, write); end
    if (addr !== 6'd0)        begin failures++; $display("FAIL rm_addr: got %0d expected 0", addr); end
    if (data_write !== 8'h00) begin failures++; $display("FAIL rm_dwr: got %h expected 00", data_write); end
    if (data_out !== 8'h00)   begin failures++; $display("FAIL rm_dout: got %h expected 00", data_out); end
    if (err !== 1'b0)         begin failures++; $display("FAIL rm_err: got %b expected 0", err); end
    if (busy !== 1'b0)        begin failures++; $display("FAIL rm_busy_rst: got %b expected 0", busy); end
    idle(1);
    exp_rd(7); send(8'h07);
    checks += 2;
    if (busy !== 1'b1)        begin failures++; $display("FAIL rm_instr_busy: got %b expected 1", busy); end
    if (data_out !== regs[7]) begin failures++; $display("FAIL rm_instr_dout: got %h expected %h", data_out, regs[7]); end
    cs_n = 1'b1; idle(2);
    check_empty("reset_mid");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 8'(i * 7 + 16);
    regs[3] = 8'hA3;
    regs[4] = 8'hB4;
    rst = 1'b1; cs_n = 1'b1; byte_sync = 1'b0; data_in = 8'h00;
    fork
      monitor();
    join_none
    test_reset();
    test_single_write();
    test_burst_read();
    test_burst_wrap();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_dcd_burst.md
INSTR_DCD_BURST -- requirements
Module: instr_dcd_burst

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, register address width (1..6).
REQ-002 SHALL have parameter REG_COUNT, default 64, number of implemented registers (1..2^ADDR_W).
REQ-003 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cs_n  in  1  SPI frame select, synchronous to clk; high = no frame.
REQ-006 SHALL have port byte_sync  in  1  one-cycle pulse, data_in holds a complete received byte.
REQ-007 SHALL have port data_in  in  8  received SPI byte.
REQ-008 SHALL have port data_out  out  8  byte for SPI slave to shift out (last read value).
REQ-009 SHALL have port read  out  1  one-cycle register read strobe.
REQ-010 SHALL have port write  out  1  one-cycle register write strobe.
REQ-011 SHALL have port addr  out  ADDR_W  register address, valid with read/write.
REQ-012 SHALL have port data_read  in  8  register read data, combinational from addr.
REQ-013 SHALL have port data_write  out  8  register write data, valid with write.
REQ-014 SHALL have port err  out  1  sticky frame error flag.
REQ-015 SHALL have port busy  out  1  high while a frame is past its instruction byte.

Function
REQ-016 Instruction byte SHALL be decoded as: bit7 = 1 write / 0 read; bit6 = 1 burst (auto-increment) / 0 single; bits[ADDR_W-1:0] = start address; unused upper bits ignored.
REQ-017 FSM SHALL have states S_INSTR (await instruction), S_DATA (transfer data bytes), S_DONE (ignore bytes until frame ends).
REQ-018 S_INSTR + byte_sync: valid address -> S_DATA; address >= REG_COUNT -> err=1, S_DONE, no strobe issued.
REQ-019 Read instruction accepted at cycle t SHALL drive read=1, addr=A at t+1 (prefetch) and load data_out with data_read at t+2.
REQ-020 Write instruction SHALL issue no strobe; address held internally.
REQ-021 S_DATA + byte_sync at t, write mode: write=1, addr=current address, data_write=data_in at t+1.
REQ-022 S_DATA + byte_sync at t, read mode: data_in ignored; burst -> read=1 at addr+1 at t+1, data_out updated at t+2; single -> no strobe.
REQ-023 After each data byte: burst -> address increments, wraps REG_COUNT-1 -> 0, stay S_DATA; single -> S_DONE.
REQ-024 S_DONE SHALL ignore byte_sync; no strobes.
REQ-025 cs_n=1 in any cycle SHALL force S_INSTR next cycle; byte_sync coincident with cs_n=1 is ignored; strobes already scheduled for that cycle's outputs still complete.
REQ-026 err SHALL hold until the first cycle of the next frame (cs_n 1 -> 0), then clear.
REQ-027 read and write SHALL never be high in the same cycle; each strobe lasts exactly one cycle.
REQ-028 busy SHALL be high in S_DATA and S_DONE, low in S_INSTR.
REQ-029 data_out SHALL change only one cycle after a read strobe; otherwise holds.

Reset
REQ-030 rst=1 SHALL set state S_INSTR, read=0, write=0, addr=0, data_write=0x00, data_out=0x00, err=0, busy=0, internal address and mode cleared, next cycle.
REQ-031 rst SHALL take priority over cs_n and byte_sync; reset mid-frame aborts frame, no further strobes.

Verification
REQ-032 Single write: cs_n=0, bytes 0x85, 0x5A -> one write, addr=5, data_write=0x5A, one cycle after 2nd byte_sync; 3rd byte 0x11 ignored.
REQ-033 Burst read: regs[3]=0xA3, regs[4]=0xB4, bytes 0x43, 0x00, 0x00 -> read at addr 3, 4, 5; data_out=0xA3 then 0xB4, each 2 cycles after triggering byte_sync.
REQ-034 Burst write wrap (ADDR_W=6, REG_COUNT=64): bytes 0xFE, 0x01, 0x02, 0x03 -> writes addr 62, 63, 0 with data 0x01, 0x02, 0x03.
REQ-035 Out of range (REG_COUNT=16): bytes 0x94, 0x77 -> err=1, no strobes, busy=1; cs_n 1 then 0 -> err=0, state S_INSTR.
REQ-036 Abort: burst write 0xC0, 0x10, cs_n=1, then new frame 0x02, 0x00 -> write addr 0 only, then read addr 2 from fresh frame.
REQ-037 Reset mid-burst read: rst=1 between data bytes -> all outputs reset values next cycle; subsequent byte_sync treated as instruction.
